// File: rtl/calendar_counter_chain_if.sv
// Field-addressed load bus for the calendar counter chain.
// The master drives a write request; the slave answers with a rejection pulse.
interface calendar_counter_chain_if #(
  parameter int DATA_W = 7
);
  logic              load;
  logic [2:0]        sel;
  logic [DATA_W-1:0] databus;
  logic              load_err;

  modport master (output load, output sel, output databus, input load_err);
  modport slave  (input load, input sel, input databus, output load_err);
endinterface

// File: rtl/calendar_counter_chain.sv
// Prescaled second/minute/hour/day/date/month/year chain with 12h/24h mode,
// leap-year month lengths, range-checked field loads and rollover pulses.
module calendar_counter_chain #(
  parameter int CLK_DIV  = 1,
  parameter int YEAR_W   = 7,
  parameter int YEAR_MAX = 99,
  parameter int MODE_12H = 0,
  parameter int DATA_W   = 7
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  calendar_counter_chain_if.slave bus,
  output logic [5:0]            sec,
  output logic [5:0]            min,
  output logic [4:0]            hour,
  output logic                  pm,
  output logic [2:0]            day,
  output logic [4:0]            date,
  output logic [3:0]            month,
  output logic [YEAR_W-1:0]     year,
  output logic                  sec_count,
  output logic                  min_count,
  output logic                  hour_count,
  output logic                  date_count,
  output logic                  year_count
);

  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [4:0]    HOUR_RST = (MODE_12H != 0) ? 5'd12 : 5'd0;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      4'd2:                    month_len = leap ? 5'd29 : 5'd28;
      default:                 month_len = 5'd31;
    endcase
  endfunction

  logic [PW-1:0]     presc;
  logic [DATA_W-1:0] d;
  logic              tick;
  logic              sec_wrap, min_wrap, hour_wrap, date_wrap, month_wrap, year_wrap;
  logic [4:0]        cur_len;
  logic [4:0]        ld_len;
  logic              load_ok;

  assign d = bus.databus;

  always_comb begin
    tick       = enable && !bus.load && (presc == PRE_LAST);
    cur_len    = month_len(month, year[1:0] == 2'b00);
    sec_wrap   = (sec == 6'd59);
    min_wrap   = sec_wrap && (min == 6'd59);
    // In 12h mode the day turns over on 11 PM -> 12 AM, not on the 12 -> 1 step.
    if (MODE_12H != 0) hour_wrap = min_wrap && (hour == 5'd11) && pm;
    else               hour_wrap = min_wrap && (hour == 5'd23);
    date_wrap  = hour_wrap && (date >= cur_len);
    month_wrap = date_wrap && (month == 4'd12);
    year_wrap  = month_wrap && (year == YEAR_W'(YEAR_MAX));
  end

  always_comb begin
    load_ok = 1'b0;
    case (bus.sel)
      3'd0, 3'd1: load_ok = (d <= DATA_W'(59));
      3'd2: begin
        if (MODE_12H != 0) load_ok = (d >= DATA_W'(1)) && (d <= DATA_W'(12));
        else               load_ok = (d <= DATA_W'(23));
      end
      3'd3: load_ok = (d <= DATA_W'(6));
      3'd4: load_ok = (d >= DATA_W'(1)) && (d <= DATA_W'(cur_len));
      3'd5: load_ok = (d >= DATA_W'(1)) && (d <= DATA_W'(12));
      3'd6: load_ok = (d <= DATA_W'(YEAR_MAX));
      default: load_ok = (MODE_12H != 0) && (d <= DATA_W'(1));
    endcase
  end

  // Month length as it will be after a month or year load, used to clamp date.
  always_comb begin
    ld_len = cur_len;
    if (bus.sel == 3'd5)      ld_len = month_len(d[3:0], year[1:0] == 2'b00);
    else if (bus.sel == 3'd6) ld_len = month_len(month, d[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      presc      <= '0;
      sec        <= '0;
      min        <= '0;
      hour       <= HOUR_RST;
      pm         <= 1'b0;
      day        <= '0;
      date       <= 5'd1;
      month      <= 4'd1;
      year       <= '0;
      sec_count  <= 1'b0;
      min_count  <= 1'b0;
      hour_count <= 1'b0;
      date_count <= 1'b0;
      year_count <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      sec_count  <= 1'b0;
      min_count  <= 1'b0;
      hour_count <= 1'b0;
      date_count <= 1'b0;
      year_count <= 1'b0;
      bus.load_err <= 1'b0;
      if (bus.load) begin
        presc <= '0;
        if (!load_ok) begin
          bus.load_err <= 1'b1;
        end else begin
          case (bus.sel)
            3'd0: sec  <= d[5:0];
            3'd1: min  <= d[5:0];
            3'd2: hour <= d[4:0];
            3'd3: day  <= d[2:0];
            3'd4: date <= d[4:0];
            3'd5: begin
              month <= d[3:0];
              if (date > ld_len) date <= ld_len;
            end
            3'd6: begin
              year <= d[YEAR_W-1:0];
              if (date > ld_len) date <= ld_len;
            end
            default: pm <= d[0];
          endcase
        end
      end else if (enable) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          sec        <= sec_wrap ? 6'd0 : sec + 6'd1;
          sec_count  <= sec_wrap;
          min_count  <= min_wrap;
          hour_count <= hour_wrap;
          date_count <= date_wrap;
          year_count <= year_wrap;
          if (sec_wrap) min <= min_wrap ? 6'd0 : min + 6'd1;
          if (min_wrap) begin
            if (MODE_12H != 0) begin
              if (hour == 5'd11) begin
                hour <= 5'd12;
                pm   <= !pm;
              end else if (hour == 5'd12) begin
                hour <= 5'd1;
              end else begin
                hour <= hour + 5'd1;
              end
            end else begin
              hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
          end
          if (hour_wrap) begin
            day  <= (day == 3'd6) ? 3'd0 : day + 3'd1;
            date <= date_wrap ? 5'd1 : date + 5'd1;
          end
          if (date_wrap)  month <= month_wrap ? 4'd1 : month + 4'd1;
          if (month_wrap) year  <= year_wrap ? '0 : year + YEAR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/calendar_counter_chain.md
Name: calendar_counter_chain

Overview:
- Parametrised single-block replacement for the chained second/minute/hour/day/date/month/year counters.
- Adds the following, all in one module:
  - a clock prescaler
  - selectable 12h/24h mode
  - month-length and leap-year handling
  - a field-addressed load port with range checking
  - per-field rollover pulses
- Sits under the clock top level. Feeds the display and timer-compare logic.

Parameters:
- CLK_DIV, 1: enabled clk cycles per one-second tick (>=1).
- YEAR_W, 7: width of the year field. Year is the offset from 2000.
- YEAR_MAX, 99: last year value. The year after YEAR_MAX wraps to 0.
- MODE_12H, 0: 0 = 24h hours 0..23; 1 = 12h hours 1..12 plus pm flag.
- DATA_W, 7: load bus width (>= YEAR_W, >= 6).

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous active-high reset
- enable  in  1  advances the prescaler when high; holds all counters when low
- load  in  1  write databus into the field chosen by sel this cycle
- sel  in  3  field select: 0 sec, 1 min, 2 hour, 3 day, 4 date, 5 month, 6 year, 7 pm
- databus  in  DATA_W  load value; LSB-aligned
- sec  out  6  seconds 0..59
- min  out  6  minutes 0..59
- hour  out  5  hours 0..23, or 1..12 when MODE_12H=1
- pm  out  1  afternoon flag; constant 0 when MODE_12H=0
- day  out  3  day of week 0..6
- date  out  5  day of month 1..month length
- month  out  4  month 1..12
- year  out  YEAR_W  year offset 0..YEAR_MAX
- sec_count, min_count, hour_count, date_count, year_count  out  1 each  one-cycle rollover pulses
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Clock and reset: all state changes on posedge clk. clear has priority over everything else.
- Values after clear:
  - sec=0, min=0, day=0, date=1, month=1, year=0
  - hour=0 (24h) or hour=12 with pm=0 (12h)
  - prescaler=0
  - all pulse outputs = 0
- Prescaler and tick:
  - Counts 0..CLK_DIV-1, only on cycles with enable=1.
  - tick is an internal signal, asserted when enable=1 and prescaler==CLK_DIV-1. The prescaler then returns to 0.
  - With CLK_DIV=1, every enabled cycle is a tick.
- Cascade: the whole cascade resolves in the tick cycle; all fields update in the same edge.
  - sec increments. 59 -> 0 pulses sec_count and increments min.
  - min 59 -> 0 pulses min_count and increments hour.
  - 24h: hour 23 -> 0 pulses hour_count and advances the day.
  - 12h: hour 11 -> 12 toggles pm, 12 -> 1, others +1. The advance from 11 with pm=1 (to 12 AM) pulses hour_count and advances the day.
  - Day advance: day 6 -> 0, otherwise +1. date increments.
  - date == month length -> date 1, date_count pulses, month increments.
  - month 12 -> 1, year increments.
  - year YEAR_MAX -> 0, year_count pulses.
- Month length:
  - 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11.
  - February is 29 when year[1:0]==0, else 28.
- Pulses are registered outputs, high for exactly the one cycle after the causing edge.
- Load:
  - When load=1, the selected field takes databus, and the prescaler is cleared to 0.
  - No tick is taken in a cycle with load=1, including the one-second increment.
- Load validity: a value is rejected if it is outside the field's range.
  - Range is as listed under Ports. For date, the range is 1..length of the current month/year.
  - sel=7 is also rejected when MODE_12H=0.
  - A rejected load changes no state, pulses load_err, and still clears the prescaler.
- Load side effects:
  - A valid month or year load that leaves date above the new month length clamps date to that length in the same edge.
  - Loads never generate rollover pulses.
- enable=0: the prescaler and counters hold; loads still work.

Test Plan:
1. Defaults, CLK_DIV=1. Load 23:59:59, date 31, month 12, year 99, day 6, then one tick -> 00:00:00, date 1, month 1, year 0, day 0. sec_count, min_count, hour_count, date_count and year_count all pulse together for one cycle.
2. Leap year. Load year 24, month 2, date 28, 23:59:59, tick -> date 29, month 2. Repeat with year 25 -> date 1, month 3.
3. CLK_DIV=4, enable held high 12 cycles from clear -> sec=3, with increments on cycles 4, 8 and 12. Drop enable for 5 cycles -> sec stays 3.
4. Invalid and clamping loads:
   - sel=1 with databus=60 -> load_err pulse, min unchanged.
   - Month 1, date 31, then load month 4 -> date 30.
   - Load date 31 while month=4 -> load_err.
5. Load/tick collision. CLK_DIV=1, load sec=10 on a tick cycle -> sec=10 (not 11), prescaler 0. The next tick gives sec=11.
6. MODE_12H=1:
   - clear -> hour 12, pm 0.
   - Load 11:59:59 with pm=0, tick -> 12:00:00 with pm=1, no hour_count.
   - Load 11:59:59 with pm=1, tick -> 12:00:00 with pm=0, hour_count pulses, day+1.
   - clear asserted mid-count -> reset values on the next edge.
